// File: rtl/toggle_activity_monitor_if.sv
// Purpose: bundles the vector-input and result-output channels of toggle_activity_monitor.
// Ports:   clear, vec_valid/vec_data/vec_ready (input channel),
//          res_valid/res_ready/res_toggles/res_peak/res_overflow (result channel).
interface toggle_activity_monitor_if #(
  parameter int W     = 14,
  parameter int CNT_W = 16
);
  localparam int PW = $clog2(W + 1);

  logic             clear;
  logic             vec_valid;
  logic [W-1:0]     vec_data;
  logic             vec_ready;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_toggles;
  logic [PW-1:0]    res_peak;
  logic             res_overflow;

  // Environment side: drives vectors and consumes results.
  modport master (
    output clear, vec_valid, vec_data, res_ready,
    input  vec_ready, res_valid, res_toggles, res_peak, res_overflow
  );

  // Monitor side.
  modport slave (
    input  clear, vec_valid, vec_data, res_ready,
    output vec_ready, res_valid, res_toggles, res_peak, res_overflow
  );
endinterface

// File: rtl/toggle_activity_monitor.sv
// Purpose: counts bit toggles between consecutive accepted vectors, reports per-window
//          total, peak per-sample toggles and accumulator overflow.
// Ports:   clk, rst (async, active-high), bus (toggle_activity_monitor_if.slave).
// Latency: res_valid rises the cycle after the WINDOW-th counted accept.
// Backpressure: vec_ready is low while a result is pending and while clear is high.
// Option:  define TOGGLE_SATURATE_EN to saturate the accumulator instead of wrapping.
module toggle_activity_monitor #(
  parameter int W      = 14,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  toggle_activity_monitor_if.slave bus
);
  localparam int PW = $clog2(W + 1);
  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t           state;
  logic [W-1:0]     prev;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [PW-1:0]    peak;
  logic             ovf;

  logic [W-1:0]     diff;
  logic [PW-1:0]    t;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] acc_next;
  logic [CNT_W-1:0] count_next;
  logic             accept;

  assign bus.vec_ready    = ~bus.clear & (state != REPORT);
  assign bus.res_valid    = (state == REPORT);
  assign bus.res_toggles  = acc;
  assign bus.res_peak     = peak;
  assign bus.res_overflow = ovf;

  assign accept     = bus.vec_valid & bus.vec_ready;
  assign diff       = bus.vec_data ^ prev;
  assign count_next = count + 1'b1;

  always_comb begin
    t = '0;
    for (int i = 0; i < W; i++) begin
      t = t + PW'(diff[i]);
    end
  end

  // One extra bit captures the carry out of the accumulator.
  assign sum = {1'b0, acc} + (CNT_W + 1)'(t);

`ifdef TOGGLE_SATURATE_EN
  assign acc_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
  assign acc_next = sum[CNT_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev  <= '0;
      acc   <= '0;
      count <= '0;
      peak  <= '0;
      ovf   <= 1'b0;
    end else if (bus.clear) begin
      state <= IDLE;
      prev  <= '0;
      acc   <= '0;
      count <= '0;
      peak  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // First vector is only a reference; nothing to compare it with.
          if (accept) begin
            prev  <= bus.vec_data;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            prev  <= bus.vec_data;
            acc   <= acc_next;
            ovf   <= ovf | sum[CNT_W];
            count <= count_next;
            if (t > peak) peak <= t;
            if (count_next == WIN) state <= REPORT;
          end
        end
        REPORT: begin
          // prev is kept so the next window continues from the last vector.
          if (bus.res_ready) begin
            acc   <= '0;
            count <= '0;
            peak  <= '0;
            ovf   <= 1'b0;
            state <= ACCUM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_toggle_activity_monitor.sv
module tb_toggle_activity_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  toggle_activity_monitor_if #(.W(14), .CNT_W(16)) aif ();
  toggle_activity_monitor_if #(.W(14), .CNT_W(4))  bif ();

  toggle_activity_monitor #(.W(14), .WINDOW(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(aif.slave)
  );
  toggle_activity_monitor #(.W(14), .WINDOW(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bif.slave)
  );

  typedef struct {
    logic [15:0] tog;
    logic [3:0]  peak;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [13:0] data;
    int          gap;
    logic        ends;
    logic [15:0] tog;
    logic [3:0]  peak;
    logic        ovf;
  } row_t;

  res_t exp_q[$];
  row_t tbl[$];
  res_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void add_row(input logic [13:0] d, input int gap, input logic ends,
                                  input logic [15:0] tog, input logic [3:0] peak, input logic ovf);
    row_t r;
    r.data = d; r.gap = gap; r.ends = ends; r.tog = tog; r.peak = peak; r.ovf = ovf;
    tbl.push_back(r);
  endfunction

  // Result monitor for dut_a: compare each handshaken result with the scoreboard.
  always @(negedge clk) begin
    if (!rst && aif.res_valid && aif.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report actual=%0d required=none", aif.res_toggles);
      end else begin
        mon_e = exp_q.pop_front();
        check("rep_toggles", 32'(aif.res_toggles), 32'(mon_e.tog));
        check("rep_peak", 32'(aif.res_peak), 32'(mon_e.peak));
        check("rep_overflow", 32'(aif.res_overflow), 32'(mon_e.ovf));
      end
    end
  end

  task automatic send_a(input logic [13:0] d);
    int n = 0;
    aif.vec_valid = 1'b1;
    aif.vec_data  = d;
    @(negedge clk);
    while (!aif.vec_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!aif.vec_ready) begin
      checks++;
      errors++;
      $display("FAIL send_a_timeout actual=vec_ready0 required=vec_ready1");
    end
    @(posedge clk);
    #1;
    aif.vec_valid = 1'b0;
  endtask

  task automatic send_b(input logic [13:0] d);
    int n = 0;
    bif.vec_valid = 1'b1;
    bif.vec_data  = d;
    @(negedge clk);
    while (!bif.vec_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bif.vec_ready) begin
      checks++;
      errors++;
      $display("FAIL send_b_timeout actual=vec_ready0 required=vec_ready1");
    end
    @(posedge clk);
    #1;
    bif.vec_valid = 1'b0;
  endtask

  task automatic apply_rows(input int lo, input int hi);
    res_t e;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].ends) begin
        e.tog = tbl[i].tog; e.peak = tbl[i].peak; e.ovf = tbl[i].ovf;
        exp_q.push_back(e);
      end
      send_a(tbl[i].data);
      check($sformatf("res_valid_after_row%0d", i), 32'(aif.res_valid), 32'(tbl[i].ends));
      if (tbl[i].gap > 0) begin
        repeat (tbl[i].gap) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    // rows 0-4: back-to-back first window (reference + 4 counted)
    add_row(14'h0000, 0, 1'b0, 0, 0, 0);
    add_row(14'h3FFF, 0, 1'b0, 0, 0, 0);
    add_row(14'h0000, 0, 1'b0, 0, 0, 0);
    add_row(14'h0001, 0, 1'b0, 0, 0, 0);
    add_row(14'h0001, 0, 1'b1, 16'd29, 4'd14, 1'b0);
    // rows 5-8: window continuing from prev=0x0001: 1+2+8+4
    add_row(14'h0003, 0, 1'b0, 0, 0, 0);
    add_row(14'h0000, 0, 1'b0, 0, 0, 0);
    add_row(14'h00FF, 0, 1'b0, 0, 0, 0);
    add_row(14'h00F0, 0, 1'b1, 16'd15, 4'd8, 1'b0);
    // rows 9-10: two counted samples before a clear
    add_row(14'h0000, 0, 1'b0, 0, 0, 0);
    add_row(14'h0F00, 0, 1'b0, 0, 0, 0);
    // rows 11-15: after clear, gapped: reference 0x3FFF then 14+14+1+0
    add_row(14'h3FFF, 3, 1'b0, 0, 0, 0);
    add_row(14'h0000, 3, 1'b0, 0, 0, 0);
    add_row(14'h3FFF, 3, 1'b0, 0, 0, 0);
    add_row(14'h3FFE, 3, 1'b0, 0, 0, 0);
    add_row(14'h3FFE, 3, 1'b1, 16'd29, 4'd14, 1'b0);
    // rows 16-20: after async reset, reference 0x00FF then 8+2+1+1
    add_row(14'h00FF, 0, 1'b0, 0, 0, 0);
    add_row(14'h0000, 0, 1'b0, 0, 0, 0);
    add_row(14'h0003, 0, 1'b0, 0, 0, 0);
    add_row(14'h0007, 0, 1'b0, 0, 0, 0);
    add_row(14'h000F, 0, 1'b1, 16'd12, 4'd8, 1'b0);

    aif.clear = 1'b0; aif.vec_valid = 1'b0; aif.vec_data = '0; aif.res_ready = 1'b0;
    bif.clear = 1'b0; bif.vec_valid = 1'b0; bif.vec_data = '0; bif.res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_res_valid", 32'(aif.res_valid), 0);
    check("reset_res_toggles", 32'(aif.res_toggles), 0);
    check("reset_res_peak", 32'(aif.res_peak), 0);
    check("reset_res_overflow", 32'(aif.res_overflow), 0);
    check("reset_vec_ready", 32'(aif.vec_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First window with the consumer stalled, then a 10-cycle hold.
    apply_rows(0, 4);
    check("win1_toggles", 32'(aif.res_toggles), 29);
    check("win1_peak", 32'(aif.res_peak), 14);
    check("win1_overflow", 32'(aif.res_overflow), 0);
    aif.vec_valid = 1'b1;
    aif.vec_data  = 14'h2AAA;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold_cycle%0d", c),
            {aif.vec_ready, aif.res_valid, 16'(aif.res_toggles), 4'(aif.res_peak)},
            {1'b0, 1'b1, 16'd29, 4'd14});
    end
    @(posedge clk);
    #1;
    aif.vec_valid = 1'b0;
    aif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    aif.res_ready = 1'b0;
    check("after_pulse_res_valid", 32'(aif.res_valid), 0);

    // Continuity: 0x0003 compared with 0x0001.
    aif.res_ready = 1'b1;
    apply_rows(5, 8);

    // Clear mid-window with a vector offered in the same cycle.
    apply_rows(9, 10);
    aif.clear     = 1'b1;
    aif.vec_valid = 1'b1;
    aif.vec_data  = 14'h3FFF;
    @(negedge clk);
    check("clear_vec_ready", 32'(aif.vec_ready), 0);
    @(posedge clk);
    #1;
    aif.clear     = 1'b0;
    aif.vec_valid = 1'b0;
    check("after_clear_res_valid", 32'(aif.res_valid), 0);
    apply_rows(11, 15);

    // Async reset while a result is pending (prev=0x3FFE): 13+1+1+2.
    aif.res_ready = 1'b0;
    send_a(14'h0000);
    send_a(14'h0001);
    send_a(14'h0000);
    send_a(14'h0003);
    check("pre_reset_res_valid", 32'(aif.res_valid), 1);
    check("pre_reset_toggles", 32'(aif.res_toggles), 17);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_res_valid", 32'(aif.res_valid), 0);
    check("async_rst_toggles", 32'(aif.res_toggles), 0);
    check("async_rst_peak", 32'(aif.res_peak), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_vec_ready", 32'(aif.vec_ready), 1);
    aif.res_ready = 1'b1;
    apply_rows(16, 20);

    // Accumulator overflow on the narrow instance.
    send_b(14'h0000);
    send_b(14'h3FFF);
    send_b(14'h0000);
    check("ovf_res_valid", 32'(bif.res_valid), 1);
`ifdef TOGGLE_SATURATE_EN
    check("ovf_toggles", 32'(bif.res_toggles), 15);
`else
    check("ovf_toggles", 32'(bif.res_toggles), 12);
`endif
    check("ovf_flag", 32'(bif.res_overflow), 1);
    check("ovf_peak", 32'(bif.res_peak), 14);
    bif.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bif.res_ready = 1'b0;
    check("ovf_flag_cleared", 32'(bif.res_overflow), 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
